pit_data_receiver: RTL and testbench

- PIT-side responder for the FIB data-propagation handshake.
- Holds a table of pending interests (prefix, len). On each FIB prefix offer it answers with an accept or reject pulse.
- On accept it receives DATA_BYTES bytes, forwards them downstream, then retires the interest.
- Sits between the FIB's incoming-data path and the downstream face/output logic.

---
 rtl/ndn_pkg.sv | 22 ++
 rtl/pit_match_array.sv | 34 +++
 rtl/pit_data_receiver.sv | 164 ++++++++++++++++
 tb/tb_pit_data_receiver.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ndn_pkg.sv
// Shared widths, table entry layout and FSM encoding for the PIT data receiver.
package ndn_pkg;
  localparam int PREFIX_W        = 64;
  localparam int LEN_W           = 6;
  localparam int BYTE_W          = 8;
  localparam int DATA_BYTES_DEF  = 1024;
  localparam int PIT_ENTRIES_DEF = 16;

  typedef struct packed {
    logic                valid;
    logic                busy;
    logic [PREFIX_W-1:0] prefix;
    logic [LEN_W-1:0]    len;
  } pit_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2,
    ST_RECV   = 2'd3
  } pit_state_t;
endpackage

// File: rtl/pit_match_array.sv
// Parallel compare of every PIT slot against a key; reports the lowest-index
// match and the lowest-index free slot.
module pit_match_array
  import ndn_pkg::*;
#(
  parameter int N     = PIT_ENTRIES_DEF,
  parameter int IDX_W = $clog2(N)
) (
  input  pit_entry_t          i_table [N],
  input  logic [PREFIX_W-1:0] i_key,
  input  logic [LEN_W-1:0]    i_key_len,
  output logic                o_hit,
  output logic [IDX_W-1:0]    o_hit_idx,
  output logic                o_free,
  output logic [IDX_W-1:0]    o_free_idx
);
  // Walk from the top down so the lowest index is the last one written.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_idx  = '0;
    o_free     = 1'b0;
    o_free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_table[i].valid && (i_table[i].prefix == i_key) && (i_table[i].len == i_key_len)) begin
        o_hit     = 1'b1;
        o_hit_idx = IDX_W'(i);
      end
      if (!i_table[i].valid) begin
        o_free     = 1'b1;
        o_free_idx = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/pit_data_receiver.sv
// PIT-side responder: records pending interests, answers FIB prefix offers with
// accept/reject, forwards DATA_BYTES bytes of an accepted packet, then retires the slot.
module pit_data_receiver
  import ndn_pkg::*;
#(
  parameter int PIT_ENTRIES = PIT_ENTRIES_DEF,
  parameter int DATA_BYTES  = DATA_BYTES_DEF,
  parameter int IDX_W       = $clog2(PIT_ENTRIES),
  parameter int CNT_W       = $clog2(DATA_BYTES) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                interest_valid,
  input  logic [PREFIX_W-1:0] interest_prefix,
  input  logic [LEN_W-1:0]    interest_len,
  output logic                interest_full,
  output logic                interest_dup,
  output logic                interest_drop,
  input  logic                prefix_ready,
  input  logic [PREFIX_W-1:0] fib_prefix,
  input  logic [LEN_W-1:0]    fib_len,
  output logic                rejected,
  output logic                start_send_to_pit,
  input  logic [BYTE_W-1:0]   in_data,
  output logic                out_valid,
  output logic [BYTE_W-1:0]   out_data,
  output logic                out_last,
  output logic [PREFIX_W-1:0] out_prefix,
  output logic [LEN_W-1:0]    out_len,
  output pit_state_t          o_dbg_state
);
  pit_entry_t          r_table [PIT_ENTRIES];
  pit_state_t          r_state, w_next;
  logic [PREFIX_W-1:0] r_key;
  logic [LEN_W-1:0]    r_key_len;
  logic                r_hit;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_dup, r_drop;
  logic                r_out_valid, r_out_last;
  logic [BYTE_W-1:0]   r_out_data;
  logic [PREFIX_W-1:0] r_out_prefix;
  logic [LEN_W-1:0]    r_out_len;

  logic w_lk_hit, w_lk_free, w_ins_hit, w_ins_free;
  logic [IDX_W-1:0] w_lk_idx, w_lk_free_idx, w_ins_idx, w_ins_free_idx;
  logic w_start, w_reject, w_retire, w_ins_write;
  logic w_unused;

  pit_match_array #(.N(PIT_ENTRIES), .IDX_W(IDX_W)) u_lookup (
    .i_table(r_table), .i_key(r_key), .i_key_len(r_key_len),
    .o_hit(w_lk_hit), .o_hit_idx(w_lk_idx), .o_free(w_lk_free), .o_free_idx(w_lk_free_idx)
  );

  pit_match_array #(.N(PIT_ENTRIES), .IDX_W(IDX_W)) u_insert (
    .i_table(r_table), .i_key(interest_prefix), .i_key_len(interest_len),
    .o_hit(w_ins_hit), .o_hit_idx(w_ins_idx), .o_free(w_ins_free), .o_free_idx(w_ins_free_idx)
  );

  // Match outputs each instance does not need.
  assign w_unused = ^{w_lk_free, w_lk_free_idx, w_ins_idx};

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_reject = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      ST_IDLE:   if (prefix_ready) w_next = ST_LOOKUP;
      ST_LOOKUP: w_next = ST_RESP;
      ST_RESP: begin
        w_start  = r_hit;
        w_reject = !r_hit;
        w_next   = r_hit ? ST_RECV : ST_IDLE;
      end
      ST_RECV: begin
        if (r_cnt == CNT_W'(DATA_BYTES - 1)) begin
          w_retire = 1'b1;
          w_next   = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key        <= '0;
      r_key_len    <= '0;
      r_hit        <= 1'b0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= '0;
      r_out_prefix <= '0;
      r_out_len    <= '0;
    end else begin
      r_out_valid <= (r_state == ST_RECV);
      r_out_last  <= w_retire;
      if (r_state == ST_IDLE && prefix_ready) begin
        r_key     <= fib_prefix;
        r_key_len <= fib_len;
      end
      if (r_state == ST_LOOKUP) begin
        r_hit <= w_lk_hit;
        r_idx <= w_lk_idx;
      end
      if (w_start) begin
        r_out_prefix <= r_key;
        r_out_len    <= r_key_len;
      end
      if (r_state == ST_RECV) begin
        r_out_data <= in_data;
        r_cnt      <= w_retire ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  // Insert decisions see the pre-edge table, so a slot retiring this edge still reads as valid.
  assign w_ins_write = interest_valid && !w_ins_hit && w_ins_free;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PIT_ENTRIES; i++) r_table[i] <= '0;
      r_dup  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_dup  <= interest_valid && w_ins_hit;
      r_drop <= interest_valid && !w_ins_hit && !w_ins_free;
      for (int i = 0; i < PIT_ENTRIES; i++) begin
        if (w_retire && r_idx == IDX_W'(i)) begin
          r_table[i].valid <= 1'b0;
          r_table[i].busy  <= 1'b0;
        end else if (w_start && r_idx == IDX_W'(i)) begin
          r_table[i].busy <= 1'b1;
        end
        if (w_ins_write && w_ins_free_idx == IDX_W'(i)) begin
          r_table[i].valid  <= 1'b1;
          r_table[i].busy   <= 1'b0;
          r_table[i].prefix <= interest_prefix;
          r_table[i].len    <= interest_len;
        end
      end
    end
  end

  assign interest_full     = !w_ins_free;
  assign interest_dup      = r_dup;
  assign interest_drop     = r_drop;
  assign start_send_to_pit = w_start;
  assign rejected          = w_reject;
  assign out_valid         = r_out_valid;
  assign out_data          = r_out_data;
  assign out_last          = r_out_last;
  assign out_prefix        = r_out_prefix;
  assign out_len           = r_out_len;
  assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_pit_data_receiver.sv
// Randomized scoreboard bench for pit_data_receiver: a driver feeds interests,
// offers and data bytes; a monitor pops expected responses as the DUT emits them.
module tb_pit_data_receiver;
  import ndn_pkg::*;

  localparam int DB = 1024;
  localparam int NS = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        interest_valid = 1'b0;
  logic [63:0] interest_prefix = '0;
  logic [5:0]  interest_len = '0;
  logic        interest_full, interest_dup, interest_drop;
  logic        prefix_ready = 1'b0;
  logic [63:0] fib_prefix = '0;
  logic [5:0]  fib_len = '0;
  logic        rejected, start_send_to_pit;
  logic [7:0]  in_data = '0;
  logic        out_valid, out_last;
  logic [7:0]  out_data;
  logic [63:0] out_prefix;
  logic [5:0]  out_len;
  pit_state_t  dbg_state;

  pit_data_receiver dut (
    .clk(clk), .rst(rst),
    .interest_valid(interest_valid), .interest_prefix(interest_prefix), .interest_len(interest_len),
    .interest_full(interest_full), .interest_dup(interest_dup), .interest_drop(interest_drop),
    .prefix_ready(prefix_ready), .fib_prefix(fib_prefix), .fib_len(fib_len),
    .rejected(rejected), .start_send_to_pit(start_send_to_pit),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_prefix(out_prefix), .out_len(out_len), .o_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: the set of pending interests as plain arrays.
  bit          m_valid [NS];
  logic [63:0] m_prefix[NS];
  logic [5:0]  m_len   [NS];

  function automatic int m_find(input logic [63:0] p, input logic [5:0] l);
    for (int i = 0; i < NS; i++)
      if (m_valid[i] && m_prefix[i] == p && m_len[i] == l) return i;
    return -1;
  endfunction

  // 0 = stored, 1 = duplicate, 2 = dropped
  function automatic int m_insert(input logic [63:0] p, input logic [5:0] l);
    if (m_find(p, l) >= 0) return 1;
    for (int i = 0; i < NS; i++)
      if (!m_valid[i]) begin
        m_valid[i] = 1; m_prefix[i] = p; m_len[i] = l;
        return 0;
      end
    return 2;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NS; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  // scoreboard queues
  logic [1:0]  exp_ins_q[$];   // insert outcome code
  logic [32:0] exp_resp_q[$];  // {accept, due cycle}
  logic [78:0] exp_data_q[$];  // {last, len, prefix, byte}

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ins_set(input logic [63:0] p, input logic [5:0] l);
    interest_valid = 1'b1; interest_prefix = p; interest_len = l;
    exp_ins_q.push_back(2'(m_insert(p, l)));
  endtask

  task automatic insert(input logic [63:0] p, input logic [5:0] l);
    ins_set(p, l);
    tick();
    interest_valid = 1'b0;
  endtask

  task automatic reset_mid();
    rst = 1'b0; #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_prefix", out_prefix, 0);
    chk("rst_out_len", out_len, 0);
    chk("rst_start", start_send_to_pit, 0);
    chk("rst_full", interest_full, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    exp_ins_q.delete(); exp_resp_q.delete(); exp_data_q.delete();
    for (int i = 0; i < NS; i++) m_valid[i] = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
  endtask

  // Offer a prefix; if the model holds it, stream DB bytes with optional hooks.
  task automatic transfer(input logic [63:0] p, input logic [5:0] l, input bit ramp,
                          input int ins_at, input logic [63:0] ins_p, input logic [5:0] ins_l,
                          input int pr_at, input logic [63:0] pr_p, input logic [5:0] pr_l,
                          input int rst_at);
    int idx;
    logic [7:0] b;
    idx = m_find(p, l);
    prefix_ready = 1'b1; fib_prefix = p; fib_len = l;
    exp_resp_q.push_back({idx >= 0, 32'(cyc + 2)});
    tick();
    prefix_ready = 1'b0; fib_prefix = 64'($urandom);
    tick();
    tick();
    if (idx < 0) begin
      chk("idle_after_reject", dbg_state, ST_IDLE);
      return;
    end
    for (int i = 0; i < DB; i++) begin
      b = ramp ? 8'(i) : 8'($urandom);
      in_data = b;
      exp_data_q.push_back({i == DB - 1, l, p, b});
      if (i == rst_at) begin
        reset_mid();
        return;
      end
      if (i == ins_at) ins_set(ins_p, ins_l);
      if (i == pr_at) begin
        prefix_ready = 1'b1; fib_prefix = pr_p; fib_len = pr_l;
      end
      tick();
      interest_valid = 1'b0;
      prefix_ready   = 1'b0;
    end
    m_valid[idx] = 0;
  endtask

  // monitor
  bit          ins_pend = 0;
  logic [1:0]  e;
  logic [32:0] r;
  logic [78:0] d;

  always @(negedge clk) begin
    if (!rst) begin
      ins_pend = 0;
    end else begin
      if (ins_pend) begin
        chk("ins_exp_avail", exp_ins_q.size() > 0, 1);
        if (exp_ins_q.size() > 0) begin
          e = exp_ins_q.pop_front();
          chk("interest_dup", interest_dup, e == 2'd1);
          chk("interest_drop", interest_drop, e == 2'd2);
        end
      end else if (interest_dup || interest_drop) begin
        chk("spurious_ins_pulse", {interest_dup, interest_drop}, 0);
      end
      ins_pend = interest_valid;

      if (start_send_to_pit || rejected) begin
        chk("resp_exp_avail", exp_resp_q.size() > 0, 1);
        chk("resp_onehot", start_send_to_pit && rejected, 0);
        if (exp_resp_q.size() > 0) begin
          r = exp_resp_q.pop_front();
          chk("resp_accept", start_send_to_pit, r[32]);
          chk("resp_cycle", 64'(cyc), 64'(r[31:0]));
        end
      end else if (exp_resp_q.size() > 0 && 64'(exp_resp_q[0][31:0]) < 64'(cyc)) begin
        r = exp_resp_q.pop_front();
        chk("resp_missing_cycle", 64'(cyc), 64'(r[31:0]));
      end

      if (out_valid) begin
        chk("data_exp_avail", exp_data_q.size() > 0, 1);
        if (exp_data_q.size() > 0) begin
          d = exp_data_q.pop_front();
          chk("out_data", out_data, d[7:0]);
          chk("out_last", out_last, d[78]);
          chk("out_prefix", out_prefix, d[71:8]);
          chk("out_len", out_len, d[77:72]);
        end
      end else if (out_last) begin
        chk("last_without_valid", out_last, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  // stimulus
  logic [63:0] p_a, q_a, n_a, x_a;
  logic [63:0] rp[NS];
  logic [63:0] pool[4];
  int op, k;

  initial begin
    for (int i = 0; i < NS; i++) m_valid[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_prefix", out_prefix, 0);
    chk("reset_out_len", out_len, 0);
    chk("reset_rejected", rejected, 0);
    chk("reset_start", start_send_to_pit, 0);
    chk("reset_dup", interest_dup, 0);
    chk("reset_drop", interest_drop, 0);
    chk("reset_full", interest_full, 0);
    chk("reset_state", dbg_state, ST_IDLE);
    tick();

    // empty table offer, then a full ramp transfer and a re-offer of the retired prefix
    transfer(64'hDEAD, 6'd8, 0, -1, 0, 0, -1, 0, 0, -1);
    insert(64'hA5A5_0000_0000_0001, 6'd16);
    transfer(64'hA5A5_0000_0000_0001, 6'd16, 1, -1, 0, 0, -1, 0, 0, -1);
    transfer(64'hA5A5_0000_0000_0001, 6'd16, 0, -1, 0, 0, -1, 0, 0, -1);

    // length mismatch, aggregation, busy-slot dup, ignored offer during a transfer
    p_a = {$urandom, $urandom};
    q_a = {$urandom, $urandom} ^ 64'h1;
    insert(p_a, 6'd16);
    transfer(p_a, 6'd17, 0, -1, 0, 0, -1, 0, 0, -1);
    repeat (15) insert(p_a, 6'd16);
    chk("full_after_dups", interest_full, 0);
    insert(q_a, 6'd20);
    transfer(p_a, 6'd16, 0, 10, p_a, 6'd16, 200, q_a, 6'd20, -1);
    transfer(q_a, 6'd20, 0, -1, 0, 0, -1, 0, 0, -1);

    // fill the table, overflow, and slot reuse around a retire
    for (int i = 0; i < NS; i++) begin
      rp[i] = {32'h5EED_0000 | 32'(i), $urandom};
      insert(rp[i], 6'(i + 1));
    end
    chk("full_when_filled", interest_full, m_count() == NS);
    x_a = 64'hFFFF_0000_0000_0017;
    insert(x_a, 6'd1);
    n_a = 64'h0123_4567_89AB_CDEF;
    transfer(rp[3], 6'd4, 0, DB - 1, n_a, 6'd9, -1, 0, 0, -1);
    chk("full_after_retire", interest_full, m_count() == NS);
    insert(n_a, 6'd9);
    chk("full_after_reuse", interest_full, m_count() == NS);
    insert(x_a, 6'd2);

    // reset in the middle of a transfer
    transfer(rp[5], 6'd6, 0, -1, 0, 0, -1, 0, 0, 500);
    transfer(rp[5], 6'd6, 0, -1, 0, 0, -1, 0, 0, -1);

    // random mix over a small prefix pool
    for (int i = 0; i < 4; i++) pool[i] = {$urandom, 32'(i)};
    for (int i = 0; i < 14; i++) begin
      op = $urandom_range(0, 2);
      k  = $urandom_range(0, 3);
      if (op < 2) insert(pool[k], 6'(k));
      else transfer(pool[k], 6'(k), 0, $urandom_range(0, DB - 1), pool[$urandom_range(0, 3)], 6'($urandom_range(0, 3)),
                    -1, 0, 0, -1);
      chk("full_random", interest_full, m_count() == NS);
    end

    repeat (4) tick();
    chk("ins_queue_drained", exp_ins_q.size(), 0);
    chk("resp_queue_drained", exp_resp_q.size(), 0);
    chk("data_queue_drained", exp_data_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
